// File: rtl/sub23seq.sv
// Multi-cycle 23-bit subtractor: out = A + ~B + 1, CHUNK bits per cycle with a registered carry.
// Define SUB23_SAT_EN to clamp underflowing results to zero (borrow still reports 1).
module sub23seq #(
    parameter int WIDTH = 22,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH:0]   A,
    input  logic [WIDTH:0]   B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out,
    output logic             borrow
);

    localparam int W    = WIDTH + 1;
    localparam int NCH  = (W + CHUNK - 1) / CHUNK;
    localparam int LAST = W - (NCH - 1) * CHUNK;
    localparam int KW   = (NCH > 1) ? $clog2(NCH) : 1;
    // Ones shifted into ~B from the top so a partial final chunk still yields the bit-W carry.
    localparam logic [W-1:0] BFILL = ~({W{1'b1}} >> CHUNK);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t              state;
    logic [W-1:0]        a_r;
    logic [W-1:0]        b_r;
    logic [W-1:0]        res;
    logic                carry;
    logic [KW-1:0]       k;
    logic                last;
    logic [CHUNK:0]      csum;
    logic [W+CHUNK-1:0]  tmp;
    logic [W-1:0]        shifted;

    always_comb begin
        last    = (k == KW'(NCH - 1));
        csum    = {1'b0, a_r[CHUNK-1:0]} + {1'b0, b_r[CHUNK-1:0]} + (CHUNK + 1)'(carry);
        tmp     = {csum[CHUNK-1:0], res};
        // The final chunk may be partial, so it shifts in only LAST bits to realign the result.
        shifted = last ? W'(tmp >> LAST) : W'(tmp >> CHUNK);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            res       <= '0;
            borrow    <= 1'b0;
            carry     <= 1'b0;
            k         <= '0;
            a_r       <= '0;
            b_r       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r      <= A;
                        b_r      <= ~B;
                        carry    <= 1'b1;
                        k        <= '0;
                        in_ready <= 1'b0;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    a_r   <= a_r >> CHUNK;
                    b_r   <= (b_r >> CHUNK) | BFILL;
                    carry <= csum[CHUNK];
                    if (last) begin
                        k         <= '0;
                        borrow    <= ~csum[CHUNK];
                        out_valid <= 1'b1;
                        state     <= DONE;
`ifdef SUB23_SAT_EN
                        res       <= csum[CHUNK] ? shifted : '0;
`else
                        res       <= shifted;
`endif
                    end else begin
                        k   <= k + KW'(1);
                        res <= shifted;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign out = res;

endmodule

// File: tb/tb_sub23seq.sv
// Scoreboard bench for sub23seq: stimulus pushes expected results, a monitor pops on each output handshake.
module tb_sub23seq;

    localparam int W = 23;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  A;
    logic [W-1:0]  B;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out;
    logic          borrow;

    typedef struct {
        logic [W-1:0] d;
        logic         b;
    } exp_t;

    exp_t sbq[$];
    int   tests;
    int   fails;

    sub23seq #(.WIDTH(22), .CHUNK(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .borrow    (borrow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [W:0] act, input logic [W:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Expected result built from plain integer arithmetic on the operands.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int unsigned ai;
        int unsigned bi;
        ai  = 32'(a);
        bi  = 32'(b);
        e.b = (ai < bi);
        e.d = W'((ai - bi) & 32'h7FFFFF);
`ifdef SUB23_SAT_EN
        if (e.b) e.d = '0;
`endif
        return e;
    endfunction

    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) checkOutput("in_ready_timeout", 24'(in_ready), 24'd1);
        in_valid = 1'b1;
        A        = a;
        B        = b;
        @(posedge clk);
        sbq.push_back(model(a, b));
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input bit randomReady);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            out_ready = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid && out_ready) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        checkOutput("drain_timeout", 24'(out_valid), 24'd1);
    endtask

    task automatic runOne(input logic [W-1:0] a, input logic [W-1:0] b, input bit randomReady);
        applyStimulus(a, b);
        drain(randomReady);
    endtask

    // Monitor: any output handshake must match the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    checkOutput("unexpected_output", 24'(out), 24'h0);
                end else begin
                    e = sbq.pop_front();
                    checkOutput("result_out", 24'(out), 24'(e.d));
                    checkOutput("result_borrow", 24'(borrow), 24'(e.b));
                end
            end
        end
    end

    initial begin
        int cnt;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        tests     = 0;
        fails     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        A         = '0;
        B         = '0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_in_ready", 24'(in_ready), 24'd1);
        checkOutput("reset_out_valid", 24'(out_valid), 24'd0);
        checkOutput("reset_out", 24'(out), 24'd0);
        checkOutput("reset_borrow", 24'(borrow), 24'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic subtract with latency and in_ready return timing.
        applyStimulus(23'd100, 23'd30);
        cnt = 1;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) break;
            @(posedge clk);
            #1;
            cnt++;
        end
        checkOutput("latency_edges", 24'(cnt), 24'd4);
        checkOutput("in_ready_in_done", 24'(in_ready), 24'd0);
        @(posedge clk);
        #1;
        checkOutput("in_ready_after_hs", 24'(in_ready), 24'd1);
        checkOutput("out_valid_after_hs", 24'(out_valid), 24'd0);

        // Chunk-boundary borrow, equal operands, underflow.
        applyStimulus(23'h000100, 23'h000001);
        sbq[sbq.size()-1] = '{d: 23'h0000FF, b: 1'b0};
        drain(1'b0);
        applyStimulus(23'h7FFFFF, 23'h7FFFFF);
        sbq[sbq.size()-1] = '{d: 23'h000000, b: 1'b0};
        drain(1'b0);
        applyStimulus(23'h000000, 23'h000001);
`ifdef SUB23_SAT_EN
        sbq[sbq.size()-1] = '{d: 23'h000000, b: 1'b1};
`else
        sbq[sbq.size()-1] = '{d: 23'h7FFFFF, b: 1'b1};
`endif
        drain(1'b0);

        // Backpressure with in_valid pulsed while busy.
        out_ready = 1'b0;
        applyStimulus(23'h123456, 23'h012345);
        sbq[sbq.size()-1] = '{d: 23'h111111, b: 1'b0};
        in_valid = 1'b1;
        A        = 23'h000007;
        B        = 23'h000003;
        for (int i = 0; i < 20 && !out_valid; i++) begin
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 5; i++) begin
            checkOutput("stall_out", 24'(out), 24'h111111);
            checkOutput("stall_borrow", 24'(borrow), 24'd0);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        repeat (6) @(posedge clk);
        #1;
        checkOutput("busy_ignored_queue", 24'(sbq.size()), 24'd0);
        checkOutput("busy_ignored_valid", 24'(out_valid), 24'd0);

        // Reset in the 2nd CALC cycle.
        applyStimulus(23'h400000, 23'h000001);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        void'(sbq.pop_back());
        checkOutput("abort_out_valid", 24'(out_valid), 24'd0);
        checkOutput("abort_out", 24'(out), 24'd0);
        checkOutput("abort_borrow", 24'(borrow), 24'd0);
        checkOutput("abort_in_ready", 24'(in_ready), 24'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(23'd5, 23'd7);
`ifdef SUB23_SAT_EN
        sbq[sbq.size()-1] = '{d: 23'h000000, b: 1'b1};
`else
        sbq[sbq.size()-1] = '{d: 23'h7FFFFE, b: 1'b1};
`endif
        drain(1'b0);

        // Extremes and random traffic with random stalls.
        runOne(23'h7FFFFF, 23'h000000, 1'b0);
        runOne(23'h000000, 23'h7FFFFF, 1'b0);
        for (int i = 0; i < 150; i++) begin
            ra = W'($urandom);
            rb = (i % 4 == 0) ? ra : W'($urandom);
            runOne(ra, rb, 1'b1);
        end

        out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        checkOutput("scoreboard_empty", 24'(sbq.size()), 24'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
